// File: rtl/uart_tx_framer_pkg.sv
// Shared UART framing constants, FSM state codes and the parity helper
// used by the transmit framer and its FIFO.
package uart_tx_framer_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  typedef logic [DATA_BITS-1:0] tx_byte_t;

  function automatic logic parity_bit(input tx_byte_t b, input logic odd);
    return (^b) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Byte-side valid/ready handshake into the UART transmit framer.
interface uart_tx_framer_if;
  import uart_tx_framer_pkg::*;

  tx_byte_t i_tx_data;
  logic     i_tx_data_valid;
  logic     o_tx_ready;

  modport master (output i_tx_data, output i_tx_data_valid, input o_tx_ready);
  modport slave  (input i_tx_data, input i_tx_data_valid, output o_tx_ready);

endinterface

// File: rtl/uart_tx_framer_fifo.sv
// Synchronous byte FIFO with show-ahead read data; pointers wrap modulo FIFO_DEPTH.
module uart_tx_framer_fifo
  import uart_tx_framer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  tx_byte_t wdata_i,
  input  logic     pop_i,
  output tx_byte_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  tx_byte_t         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: queues bytes and serialises start, 8 data bits LSB-first,
// optional parity and 1-2 stop bits, with back-to-back frames when data is waiting.
module uart_tx_framer
  import uart_tx_framer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               i_tx_clk,
  input  logic               i_tx_rst,
  uart_tx_framer_if.slave    tx_bus,
  output logic               o_tx_rx_data,
  output logic               o_tx_busy,
  output logic               o_tx_done
);

  localparam int               BAUD_W    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic              ODD       = (PARITY_ODD != 0);

  logic [2:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  tx_byte_t          shift_q, shift_d;
  logic              par_q, par_d;
  logic              line_q, line_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic     fifo_pop, fifo_full, fifo_empty, baud_end;
  tx_byte_t fifo_rdata;

  uart_tx_framer_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (i_tx_clk),
    .rst_i   (i_tx_rst),
    .push_i  (tx_bus.i_tx_data_valid),
    .wdata_i (tx_bus.i_tx_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign tx_bus.o_tx_ready = ~fifo_full;
  assign baud_end          = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    line_d   = line_q;
    fifo_pop = 1'b0;
    if (state_q != S_IDLE) baud_d = baud_end ? '0 : baud_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        line_d = STOP_BIT;
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          par_d    = parity_bit(fifo_rdata, ODD);
          line_d   = START_BIT;
          state_d  = S_START;
        end
      end
      S_START: if (baud_end) begin
        state_d = S_DATA;
        bit_d   = '0;
        line_d  = shift_q[0];
      end
      S_DATA: if (baud_end) begin
        if (bit_q == DATA_LAST) begin
          bit_d = '0;
          if (PARITY_EN != 0) begin
            state_d = S_PARITY;
            line_d  = par_q;
          end else begin
            state_d = S_STOP;
            line_d  = STOP_BIT;
          end
        end else begin
          bit_d   = bit_q + 3'd1;
          shift_d = shift_q >> 1;
          line_d  = shift_q[1];
        end
      end
      S_PARITY: if (baud_end) begin
        state_d = S_STOP;
        bit_d   = '0;
        line_d  = STOP_BIT;
      end
      S_STOP: if (baud_end) begin
        if (bit_q != STOP_LAST) begin
          bit_d = bit_q + 3'd1;
        end else if (!fifo_empty) begin
          // Chain straight into the next frame so the line never idles between bytes.
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          par_d    = parity_bit(fifo_rdata, ODD);
          bit_d    = '0;
          line_d   = START_BIT;
          state_d  = S_START;
        end else begin
          state_d = S_IDLE;
          line_d  = STOP_BIT;
        end
      end
      default: begin
        state_d = S_IDLE;
        line_d  = STOP_BIT;
      end
    endcase
  end

  // done is registered from next-state so it lands in the final stop-bit cycle.
  assign done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge i_tx_clk) begin
    if (i_tx_rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      line_q  <= STOP_BIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge i_tx_clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  assign o_tx_rx_data = line_q;
  assign o_tx_busy    = busy_q;
  assign o_tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Randomised bench for uart_tx_framer: three parameterisations, line decoded by a frame model.
module tb_uart_tx_framer;

  localparam int ND = 3;
  localparam int CPB  [ND] = '{1, 4, 1};
  localparam int PEN  [ND] = '{1, 1, 0};
  localparam int PODD [ND] = '{0, 1, 0};
  localparam int NSTP [ND] = '{1, 2, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_r;
  logic       vld_r  [ND];
  logic       line_w [ND];
  logic       busy_w [ND];
  logic       done_w [ND];
  logic       rdy_w  [ND];

  always #5 clk = ~clk;

  uart_tx_framer_if bus0 ();
  uart_tx_framer_if bus1 ();
  uart_tx_framer_if bus2 ();

  assign bus0.i_tx_data = data_r;
  assign bus1.i_tx_data = data_r;
  assign bus2.i_tx_data = data_r;
  assign bus0.i_tx_data_valid = vld_r[0];
  assign bus1.i_tx_data_valid = vld_r[1];
  assign bus2.i_tx_data_valid = vld_r[2];
  assign rdy_w[0] = bus0.o_tx_ready;
  assign rdy_w[1] = bus1.o_tx_ready;
  assign rdy_w[2] = bus2.o_tx_ready;

  uart_tx_framer dut0 (.i_tx_clk(clk), .i_tx_rst(rst), .tx_bus(bus0),
    .o_tx_rx_data(line_w[0]), .o_tx_busy(busy_w[0]), .o_tx_done(done_w[0]));
  uart_tx_framer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut1 (.i_tx_clk(clk), .i_tx_rst(rst), .tx_bus(bus1),
    .o_tx_rx_data(line_w[1]), .o_tx_busy(busy_w[1]), .o_tx_done(done_w[1]));
  uart_tx_framer #(.CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut2 (.i_tx_clk(clk), .i_tx_rst(rst), .tx_bus(bus2),
    .o_tx_rx_data(line_w[2]), .o_tx_busy(busy_w[2]), .o_tx_done(done_w[2]));

  int         n_checks = 0;
  int         n_errors = 0;
  int         sel = 0;
  bit         cap_en = 1'b0;
  bit         saw_full;
  int         last_push_idx;
  logic       cap_line [$];
  logic       cap_busy [$];
  logic       cap_done [$];
  logic [7:0] exp_q [$];

  always @(negedge clk) begin
    if (cap_en) begin
      cap_line.push_back(line_w[sel]);
      cap_busy.push_back(busy_w[sel]);
      cap_done.push_back(done_w[sel]);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_cap(input int d);
    sel = d;
    cap_line.delete();
    cap_busy.delete();
    cap_done.delete();
    exp_q.delete();
    cap_en = 1'b1;
  endtask

  task automatic push(input int d, input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    data_r   = b;
    vld_r[d] = 1'b1;
    while (!rdy_w[d] && t < 5000) begin
      saw_full = 1'b1;
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      check_val("push_timeout", t, 0);
      vld_r[d] = 1'b0;
      return;
    end
    @(posedge clk);
    last_push_idx = cap_line.size();
    #1;
    vld_r[d] = 1'b0;
    exp_q.push_back(b);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    repeat (3) @(negedge clk);
    while (busy_w[sel] && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 4000) check_val({tag, "_idle_timeout"}, t, 0);
    repeat (4) @(negedge clk);
    cap_en = 1'b0;
  endtask

  // Reference receiver: walk the captured line, expect one frame per queued byte.
  task automatic analyze(input string tag, output int gaps);
    int n, i, cpb, nbits, idx, g, line_err, busy_err, done_err, idle_err;
    logic [7:0] b, rx;
    logic ebit;
    n = cap_line.size(); i = 0; gaps = 0; idle_err = 0;
    cpb   = CPB[sel];
    nbits = 1 + 8 + PEN[sel] + NSTP[sel];
    for (int f = 0; f < exp_q.size(); f++) begin
      b = exp_q[f]; g = 0;
      while (i < n && cap_line[i] == 1'b1) begin
        if (cap_busy[i] !== 1'b0 || cap_done[i] !== 1'b0) idle_err++;
        i++; g++;
      end
      if (f > 0) gaps += g;
      if (i + nbits * cpb > n) begin
        check_val({tag, "_frame_missing"}, f, exp_q.size());
        break;
      end
      line_err = 0; busy_err = 0; done_err = 0; rx = '0;
      for (int k = 0; k < nbits; k++) begin
        if (k == 0)                       ebit = 1'b0;
        else if (k <= 8)                  ebit = b[k-1];
        else if (PEN[sel] != 0 && k == 9) ebit = logic'(($countones(b) % 2) ^ PODD[sel]);
        else                              ebit = 1'b1;
        for (int c = 0; c < cpb; c++) begin
          idx = i + k * cpb + c;
          if (cap_line[idx] !== ebit) line_err++;
          if (cap_busy[idx] !== 1'b1) busy_err++;
          if (cap_done[idx] !== logic'(k == nbits - 1 && c == cpb - 1)) done_err++;
        end
        if (k >= 1 && k <= 8) rx[k-1] = cap_line[i + k * cpb + cpb / 2];
      end
      check_val({tag, "_rx_byte"}, rx, b);
      check_val({tag, "_line_bits"}, line_err, 0);
      check_val({tag, "_busy"}, busy_err, 0);
      check_val({tag, "_done"}, done_err, 0);
      i += nbits * cpb;
    end
    while (i < n) begin
      if (cap_line[i] !== 1'b1 || cap_busy[i] !== 1'b0 || cap_done[i] !== 1'b0) idle_err++;
      i++;
    end
    check_val({tag, "_idle"}, idle_err, 0);
  endtask

  task automatic random_burst(input int d, input int nbytes, input string tag);
    int g;
    start_cap(d);
    for (int k = 0; k < nbytes; k++) begin
      push(d, 8'($urandom));
      repeat ($urandom_range(0, 15)) @(negedge clk);
    end
    wait_idle(tag);
    analyze(tag, g);
  endtask

  initial begin
    int p, g, mism, dn, cnt, errs;
    bit exp_seq [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    rst = 1'b1;
    data_r = '0;
    for (int d = 0; d < ND; d++) vld_r[d] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check_val($sformatf("rst_line%0d", d), line_w[d], 1);
      check_val($sformatf("rst_busy%0d", d), busy_w[d], 0);
      check_val($sformatf("rst_done%0d", d), done_w[d], 0);
      check_val($sformatf("rst_ready%0d", d), rdy_w[d], 1);
    end
    rst = 1'b0;

    // Single A5 on the default configuration
    start_cap(0);
    repeat (2) @(negedge clk);
    push(0, 8'hA5);
    p = last_push_idx;
    wait_idle("a5");
    check_val("a5_latency_pre", cap_line[p], 1);
    check_val("a5_latency_start", cap_line[p+1], 0);
    mism = 0;
    for (int k = 0; k < 11; k++) if (cap_line[p+1+k] !== logic'(exp_seq[k])) mism++;
    check_val("a5_sequence", mism, 0);
    cnt = 0;
    foreach (cap_done[k]) if (cap_done[k] === 1'b1) cnt++;
    check_val("a5_done_count", cnt, 1);
    analyze("a5", g);

    // Back-to-back frames
    start_cap(0);
    push(0, 8'hA5);
    push(0, 8'h3C);
    push(0, 8'hFF);
    wait_idle("b2b");
    analyze("b2b", g);
    check_val("b2b_gaps", g, 0);

    // Fill the FIFO while the first frame is sending
    start_cap(0);
    saw_full = 1'b0;
    for (int k = 0; k < 6; k++) push(0, 8'($urandom));
    wait_idle("fill");
    analyze("fill", g);
    check_val("fill_ready_low", saw_full, 1);
    check_val("fill_gaps", g, 0);

    // Reset during D4 of 8'h81 with bytes still queued
    cap_en = 1'b0;
    sel = 0;
    push(0, 8'h81);
    push(0, 8'h5A);
    push(0, 8'hC3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("rst_mid_d4_line", line_w[0], 0);
    check_val("rst_mid_d4_busy", busy_w[0], 1);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_mid_line", line_w[0], 1);
    check_val("rst_mid_busy", busy_w[0], 0);
    check_val("rst_mid_ready", rdy_w[0], 1);
    check_val("rst_mid_done", done_w[0], 0);
    rst = 1'b0;
    errs = 0;
    repeat (30) begin
      @(negedge clk);
      if (line_w[0] !== 1'b1 || busy_w[0] !== 1'b0) errs++;
    end
    check_val("rst_mid_no_resume", errs, 0);
    start_cap(0);
    push(0, 8'h55);
    wait_idle("post_rst");
    analyze("post_rst", g);

    random_burst(0, 20, "rand0");

    // Odd parity, 4 clocks per bit, 2 stop bits
    start_cap(1);
    push(1, 8'h07);
    p = last_push_idx;
    wait_idle("cfg1");
    analyze("cfg1", g);
    dn = -1;
    foreach (cap_done[k]) if (dn < 0 && cap_done[k] === 1'b1) dn = k;
    check_val("cfg1_frame_len", dn - p, 48);
    check_val("cfg1_parity", cap_line[p + 1 + 9 * 4], 0);
    random_burst(1, 8, "rand1");

    // No parity bit
    start_cap(2);
    push(2, 8'h00);
    p = last_push_idx;
    wait_idle("cfg2");
    analyze("cfg2", g);
    cnt = 0;
    while (p + 1 + cnt < cap_line.size() && cap_line[p + 1 + cnt] === 1'b0) cnt++;
    check_val("cfg2_low_bits", cnt, 9);
    random_burst(2, 8, "rand2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
